// File: rtl/jtframe_status_rx.sv
// Receives OSD status frames from the IO controller byte bus and commits
// the 32-bit status word atomically; also merges the local pause hot-key.
module jtframe_status_rx #(
    parameter logic [7:0]  STATUS_CMD = 8'h1E,
    parameter logic [15:0] TIMEOUT    = 16'd4095,
    parameter logic [31:0] DEF_STATUS = 32'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        io_cs,
    input  logic        byte_stb,
    input  logic [7:0]  byte_in,
    input  logic        key_pause,
    output logic [31:0] status,
    output logic        status_upd,
    output logic        err,
    output logic        busy
);
    localparam int unsigned SW  = 32;
    localparam int unsigned BW  = 8;
    localparam int unsigned IW  = 2;
    localparam int unsigned CW  = 16;
    localparam int unsigned SHW = SW - BW;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        SKIP
    } state_t;

    state_t          state, state_nx;
    logic [IW-1:0]   idx, idx_nx;
    logic [CW-1:0]   cnt, cnt_nx;
    // the fourth byte goes straight into status, so only three are buffered
    logic [SHW-1:0]  shadow, shadow_nx;
    logic [SW-1:0]   status_nx;
    logic            upd_nx;
    logic            err_nx;
    logic            stb;
    logic            commit;

    assign stb  = io_cs & byte_stb;
    assign busy = (state != IDLE);

    // State and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            idx        <= '0;
            cnt        <= '0;
            shadow     <= '0;
            status     <= DEF_STATUS;
            status_upd <= 1'b0;
            err        <= 1'b0;
        end else begin
            state      <= state_nx;
            idx        <= idx_nx;
            cnt        <= cnt_nx;
            shadow     <= shadow_nx;
            status     <= status_nx;
            status_upd <= upd_nx;
            err        <= err_nx;
        end
    end

    // Frame decode, timeout and status merge
    always_comb begin
        state_nx  = state;
        idx_nx    = idx;
        cnt_nx    = cnt;
        shadow_nx = shadow;
        commit    = 1'b0;
        err_nx    = 1'b0;

        case (state)
            IDLE: begin
                if (stb) begin
                    if (byte_in == STATUS_CMD) begin
                        state_nx  = DATA;
                        idx_nx    = '0;
                        cnt_nx    = '0;
                        shadow_nx = '0;
                    end else begin
                        state_nx = SKIP;
                    end
                end
            end
            DATA: begin
                if (!io_cs) begin
                    state_nx  = IDLE;
                    err_nx    = 1'b1;
                    idx_nx    = '0;
                    cnt_nx    = '0;
                    shadow_nx = '0;
                end else if (byte_stb) begin
                    cnt_nx = '0;
                    idx_nx = idx + IW'(1);
                    case (idx)
                        2'd0:    shadow_nx[7:0]   = byte_in;
                        2'd1:    shadow_nx[15:8]  = byte_in;
                        2'd2:    shadow_nx[23:16] = byte_in;
                        default: begin
                            commit   = 1'b1;
                            state_nx = SKIP;
                        end
                    endcase
                end else if (cnt == TIMEOUT) begin
                    err_nx    = 1'b1;
                    state_nx  = SKIP;
                    idx_nx    = '0;
                    cnt_nx    = '0;
                    shadow_nx = '0;
                end else if (cnt != '1) begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            SKIP: begin
                if (!io_cs) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase

        // a pause toggle coinciding with a commit lands on the committed value
        status_nx = commit ? {byte_in, shadow} : status;
        if (key_pause) status_nx = status_nx ^ SW'(32'h2);
        upd_nx = commit | key_pause;
    end

endmodule

// File: tb/tb_jtframe_status_rx.sv
// Bench for jtframe_status_rx: directed vector table, hand-written timeout and
// reset sequences, then random frames against a frame-level reference model.
module tb_jtframe_status_rx;
    localparam logic [7:0]  CMD = 8'h1E;
    localparam logic [15:0] TMO = 16'd16;
    localparam logic [31:0] DEF = 32'h0000_1000;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        io_cs     = 1'b0;
    logic        byte_stb  = 1'b0;
    logic [7:0]  byte_in   = 8'h00;
    logic        key_pause = 1'b0;
    logic [31:0] status;
    logic        status_upd;
    logic        busy;
    logic        err;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Reference model: tracks the frame as a list of received data bytes
    logic [31:0] m_status;
    logic        m_active;
    logic        m_collect;
    logic [7:0]  m_q[$];
    int          m_gap;
    logic [31:0] e_status;
    logic        e_upd, e_err, e_busy;

    typedef struct {
        logic        cs;
        logic        stb;
        logic [7:0]  b;
        logic        kp;
        logic [31:0] st;
        logic        upd;
        logic        er;
        logic        bs;
    } vec_t;
    vec_t tv[$];

    jtframe_status_rx #(
        .STATUS_CMD (CMD),
        .TIMEOUT    (TMO),
        .DEF_STATUS (DEF)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .io_cs      (io_cs),
        .byte_stb   (byte_stb),
        .byte_in    (byte_in),
        .key_pause  (key_pause),
        .status     (status),
        .status_upd (status_upd),
        .err        (err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic model_step(input logic rst, input logic cs, input logic stb,
                              input logic [7:0] b, input logic kp);
        logic [31:0] nst;
        e_upd = 1'b0;
        e_err = 1'b0;
        if (!rst) begin
            m_status  = DEF;
            m_active  = 1'b0;
            m_collect = 1'b0;
            m_q.delete();
            m_gap     = 0;
        end else begin
            nst = m_status;
            if (!cs) begin
                if (m_collect) e_err = 1'b1;
                m_active  = 1'b0;
                m_collect = 1'b0;
                m_q.delete();
                m_gap     = 0;
            end else if (stb) begin
                if (!m_active) begin
                    m_active  = 1'b1;
                    m_collect = (b == CMD);
                    m_q.delete();
                    m_gap     = 0;
                end else if (m_collect) begin
                    m_q.push_back(b);
                    m_gap = 0;
                    if (m_q.size() == 4) begin
                        nst       = {m_q[3], m_q[2], m_q[1], m_q[0]};
                        e_upd     = 1'b1;
                        m_collect = 1'b0;
                    end
                end
            end else if (m_collect) begin
                if (m_gap == int'(TMO)) begin
                    e_err     = 1'b1;
                    m_collect = 1'b0;
                end else begin
                    m_gap++;
                end
            end
            if (kp) begin
                nst   = nst ^ 32'h2;
                e_upd = 1'b1;
            end
            m_status = nst;
        end
        e_status = m_status;
        e_busy   = m_active;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // One clock: drive inputs, advance model, sample 1ns after the edge
    task automatic cycle(input logic rst, input logic cs, input logic stb, input logic [7:0] b,
                         input logic kp, input logic use_model, input logic [31:0] x_st,
                         input logic x_upd, input logic x_err, input logic x_busy,
                         input string tag);
        rst_n     = rst;
        io_cs     = cs;
        byte_stb  = stb;
        byte_in   = b;
        key_pause = kp;
        model_step(rst, cs, stb, b, kp);
        if (use_model) begin
            x_st   = e_status;
            x_upd  = e_upd;
            x_err  = e_err;
            x_busy = e_busy;
        end
        @(posedge clk);
        #1;
        cyc++;
        check({tag, ".status"}, status, x_st);
        check({tag, ".upd"}, 32'(status_upd), 32'(x_upd));
        check({tag, ".err"}, 32'(err), 32'(x_err));
        check({tag, ".busy"}, 32'(busy), 32'(x_busy));
    endtask

    function automatic void add(input logic cs, input logic stb, input logic [7:0] b,
                                input logic kp, input logic [31:0] st, input logic upd,
                                input logic er, input logic bs);
        vec_t v;
        v.cs = cs; v.stb = stb; v.b = b; v.kp = kp;
        v.st = st; v.upd = upd; v.er = er; v.bs = bs;
        tv.push_back(v);
    endfunction

    task automatic rcycle(input logic cs, input logic stb, input logic [7:0] b);
        logic kp;
        kp = ($urandom_range(0, 15) == 0);
        cycle(1'b1, cs, stb, b, kp, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0, "rand");
    endtask

    task automatic random_frames(input int nframes);
        int nb, gap, nlow;
        logic [7:0] b;
        for (int f = 0; f < nframes; f++) begin
            nb = $urandom_range(0, 7);
            for (int k = 0; k < nb; k++) begin
                // gap of exactly TMO idle cycles is avoided: strobe/timeout tie
                if ($urandom_range(0, 7) == 0)
                    gap = ($urandom_range(0, 1) == 0) ? $urandom_range(10, 15)
                                                      : $urandom_range(17, 22);
                else
                    gap = $urandom_range(0, 2);
                for (int g = 0; g < gap; g++) rcycle(1'b1, 1'b0, 8'h00);
                if (k == 0 && $urandom_range(0, 3) != 0) b = CMD;
                else b = 8'($urandom);
                rcycle(1'b1, 1'b1, b);
            end
            nlow = $urandom_range(1, 3);
            for (int g = 0; g < nlow; g++)
                rcycle(1'b0, 1'($urandom_range(0, 1)), 8'($urandom));
        end
    endtask

    initial begin
        // normal frame with gaps and a fifth byte
        add(1,0,8'h00,0, 32'h0000_1000,0,0,0);
        add(1,1,8'h1E,0, 32'h0000_1000,0,0,1);
        add(1,1,8'h78,0, 32'h0000_1000,0,0,1);
        add(1,0,8'h00,0, 32'h0000_1000,0,0,1);
        add(1,1,8'h56,0, 32'h0000_1000,0,0,1);
        add(1,0,8'h00,0, 32'h0000_1000,0,0,1);
        add(1,0,8'h00,0, 32'h0000_1000,0,0,1);
        add(1,1,8'h34,0, 32'h0000_1000,0,0,1);
        add(1,1,8'h12,0, 32'h1234_5678,1,0,1);
        add(1,0,8'h00,0, 32'h1234_5678,0,0,1);
        add(1,1,8'h99,0, 32'h1234_5678,0,0,1);
        add(0,0,8'h00,0, 32'h1234_5678,0,0,0);
        // aborted frame
        add(1,1,8'h1E,0, 32'h1234_5678,0,0,1);
        add(1,1,8'hAA,0, 32'h1234_5678,0,0,1);
        add(1,1,8'hBB,0, 32'h1234_5678,0,0,1);
        add(0,0,8'h00,0, 32'h1234_5678,0,1,0);
        add(0,0,8'h00,0, 32'h1234_5678,0,0,0);
        // recovery frame
        add(1,1,8'h1E,0, 32'h1234_5678,0,0,1);
        add(1,1,8'h01,0, 32'h1234_5678,0,0,1);
        add(1,1,8'h00,0, 32'h1234_5678,0,0,1);
        add(1,1,8'h00,0, 32'h1234_5678,0,0,1);
        add(1,1,8'h00,0, 32'h0000_0001,1,0,1);
        add(0,0,8'h00,0, 32'h0000_0001,0,0,0);
        // unknown command
        add(1,1,8'h2B,0, 32'h0000_0001,0,0,1);
        add(1,1,8'hFF,0, 32'h0000_0001,0,0,1);
        add(1,1,8'hFF,0, 32'h0000_0001,0,0,1);
        add(1,1,8'hFF,0, 32'h0000_0001,0,0,1);
        add(1,1,8'hFF,0, 32'h0000_0001,0,0,1);
        add(0,0,8'h00,0, 32'h0000_0001,0,0,0);
        // zero status, then pause key while idle
        add(1,1,8'h1E,0, 32'h0000_0001,0,0,1);
        add(1,1,8'h00,0, 32'h0000_0001,0,0,1);
        add(1,1,8'h00,0, 32'h0000_0001,0,0,1);
        add(1,1,8'h00,0, 32'h0000_0001,0,0,1);
        add(1,1,8'h00,0, 32'h0000_0000,1,0,1);
        add(0,0,8'h00,0, 32'h0000_0000,0,0,0);
        add(0,0,8'h00,1, 32'h0000_0002,1,0,0);
        add(0,0,8'h00,0, 32'h0000_0002,0,0,0);
        // pause coincident with commit, then pause during skip
        add(1,1,8'h1E,0, 32'h0000_0002,0,0,1);
        add(1,1,8'hF0,0, 32'h0000_0002,0,0,1);
        add(1,1,8'h00,0, 32'h0000_0002,0,0,1);
        add(1,1,8'h00,0, 32'h0000_0002,0,0,1);
        add(1,1,8'h00,1, 32'h0000_00F2,1,0,1);
        add(1,1,8'h55,1, 32'h0000_00F0,1,0,1);
        add(1,0,8'h00,0, 32'h0000_00F0,0,0,1);
        add(0,0,8'h00,0, 32'h0000_00F0,0,0,0);

        // reset held for three clocks
        for (int i = 0; i < 3; i++)
            cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, DEF, 1'b0, 1'b0, 1'b0, "reset");

        foreach (tv[i])
            cycle(1'b1, tv[i].cs, tv[i].stb, tv[i].b, tv[i].kp, 1'b0,
                  tv[i].st, tv[i].upd, tv[i].er, tv[i].bs, $sformatf("vec%0d", i));

        // inter-byte timeout: err on the 17th idle cycle after byte 0x11
        cycle(1'b1, 1'b1, 1'b1, 8'h1E, 1'b0, 1'b0, 32'hF0, 1'b0, 1'b0, 1'b1, "tmo.cmd");
        cycle(1'b1, 1'b1, 1'b1, 8'h11, 1'b0, 1'b0, 32'hF0, 1'b0, 1'b0, 1'b1, "tmo.b0");
        for (int i = 0; i < 20; i++)
            cycle(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 32'hF0, 1'b0, 1'(i == 16), 1'b1,
                  $sformatf("tmo.wait%0d", i));
        cycle(1'b1, 1'b1, 1'b1, 8'h22, 1'b0, 1'b0, 32'hF0, 1'b0, 1'b0, 1'b1, "tmo.b1");
        cycle(1'b1, 1'b1, 1'b1, 8'h33, 1'b0, 1'b0, 32'hF0, 1'b0, 1'b0, 1'b1, "tmo.b2");
        cycle(1'b1, 1'b1, 1'b1, 8'h44, 1'b0, 1'b0, 32'hF0, 1'b0, 1'b0, 1'b1, "tmo.b3");
        cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 32'hF0, 1'b0, 1'b0, 1'b0, "tmo.end");

        // reset in mid-frame discards it without an err pulse
        cycle(1'b1, 1'b1, 1'b1, 8'h1E, 1'b0, 1'b0, 32'hF0, 1'b0, 1'b0, 1'b1, "rst.cmd");
        cycle(1'b1, 1'b1, 1'b1, 8'hAA, 1'b0, 1'b0, 32'hF0, 1'b0, 1'b0, 1'b1, "rst.b0");
        cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, DEF, 1'b0, 1'b0, 1'b0, "rst.hit");
        cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, DEF, 1'b0, 1'b0, 1'b0, "rst.after");

        random_frames(150);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/jtframe_status_rx.md
Name: jtframe_status_rx

Overview:
- Byte-stream receiver that builds the 32-bit OSD status word from the IO controller's command bus and drives the status input of the DIP/option decode stage.
- Assembles multi-byte status frames in a shadow register and commits them atomically, so downstream never sees a half-written word.
- Handles aborted frames and inter-byte timeouts, and merges a local pause hot-key that toggles status bit 1.

Parameters:
- STATUS_CMD, 8'h1E: command byte that opens a status-write frame.
- TIMEOUT, 16'd4095: maximum clk cycles allowed between bytes within a frame before the frame is aborted.
- DEF_STATUS, 32'h0: value loaded into status at reset.

Ports:
- clk  in  1: system clock.
- rst_n  in  1: synchronous reset, active low.
- io_cs  in  1: frame select; high for the whole duration of one command frame.
- byte_stb  in  1: one-cycle strobe; byte_in is valid on that cycle.
- byte_in  in  8: command/data byte.
- key_pause  in  1: one-cycle pulse; toggles status[1].
- status  out  32: committed status word, registered.
- status_upd  out  1: one-cycle pulse on the same cycle status takes a new value.
- busy  out  1: high while a frame is in progress (state != IDLE).
- err  out  1: one-cycle pulse when a status frame is aborted.

Behaviour:
- Reset (rst_n low at a clk edge), taking priority over everything:
  - status=DEF_STATUS; status_upd=0; busy=0; err=0.
  - State=IDLE; byte index=0; timeout counter=0; shadow cleared.
  - A frame in progress is discarded without an err pulse.
- Interface rule: byte_stb is ignored whenever io_cs is low.
- States: IDLE, DATA, SKIP.
- IDLE:
  - io_cs & byte_stb with byte_in==STATUS_CMD -> DATA, index=0, counter=0.
  - io_cs & byte_stb with any other byte -> SKIP.
  - io_cs high without a strobe stays in IDLE.
  - The first strobe after io_cs rises is always treated as the command byte.
- DATA:
  - Bytes arrive little-endian: byte k is written to shadow[8k+7:8k], k=0..3.
  - On the 4th strobe, at that same edge:
    - status <= {byte_in, shadow[23:0]};
    - status_upd=1 for exactly that one cycle;
    - go to SKIP.
  - Result: status is visible one cycle after the 4th strobe.
- SKIP: bytes beyond the 4th, and frames with unknown commands, are consumed and ignored until io_cs falls.
- Any state except IDLE with io_cs low -> IDLE next edge.
  - If the state was DATA (fewer than 4 bytes received), err pulses for one cycle and status is unchanged.
- Timeout:
  - The counter is active only in DATA. It clears on every accepted strobe and increments otherwise.
  - When counter==TIMEOUT: err pulses, shadow is discarded, state -> SKIP (wait for io_cs low).
  - Counter width is 16 bits; it saturates and never wraps.
- key_pause:
  - A pulse in a cycle with no commit gives status <= status ^ 32'h2, status_upd=1.
  - If it coincides with a commit, the toggle is applied to the committed value: status <= {byte_in, shadow[23:0]} ^ 32'h2, with a single status_upd pulse.
  - key_pause works in every state, including while busy.
- status_upd pulses on every commit, even when the new value equals the old one.
- busy is combinational from the registered state: high in DATA and SKIP.
- Bits of status are never partially updated. Shadow content never reaches status except through a complete 4-byte commit.

Test Plan:
- Reset: hold rst_n=0 for 3 clk with DEF_STATUS=32'h0000_1000 -> status=32'h0000_1000; busy, err, status_upd all 0.
- Normal frame: io_cs=1, strobes 1E,78,56,34,12 (gaps of 0..5 cycles), io_cs=0 -> status=32'h1234_5678 one cycle after the 0x34... (4th data byte 0x12) strobe; status_upd high exactly 1 cycle; byte 5 ignored; busy falls the cycle after io_cs falls.
- Abort: frame 1E,AA,BB with io_cs dropped early -> status unchanged, err pulses once, state IDLE. Next full frame 1E,01,00,00,00 -> status=32'h1.
- Timeout: TIMEOUT=16, send 1E,11 then wait 20 cycles with io_cs high -> err pulses at counter==16. Further bytes 22,33,44 are ignored and status is unchanged until io_cs cycles.
- Unknown command: frame 2B,FF,FF,FF,FF -> no status_upd, no err, status unchanged.
- Pause key: status=0 then key_pause -> status=32'h2. key_pause on the same edge as a commit of 32'hF0 -> status=32'hF2 with a single status_upd pulse. key_pause during SKIP also toggles bit 1.
